mealy_seq_detector: RTL and testbench

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

---
 rtl/mealy_seq_pkg.sv | 10 +
 rtl/sat_counter.sv | 27 ++
 rtl/mealy_seq_detector.sv | 60 ++++++
 tb/tb_mealy_seq_detector.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg: shared parameter limits and sizing helper for the sequence detector
package mealy_seq_pkg;
    localparam int W_MIN = 2;
    localparam int W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;
    function automatic int fill_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sticky all-ones flag and synchronous clear
module sat_counter
    import mealy_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    logic [CNT_W-1:0] nxt;
    assign nxt = count + 1'b1;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && !(&count)) begin
            count <= nxt;
            sat   <= sat | (&nxt);
        end
endmodule

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: loadable-pattern serial detector with zero-latency Mealy match output
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter int           W           = 2,
    parameter int           CNT_W       = 8,
    parameter logic [W-1:0] DEF_PATTERN = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [W-1:0]     pattern_in,
    output logic             y_out,
    output logic [CNT_W-1:0] match_count,
    output logic             match_sat
);
    localparam int FW = fill_w(W);
    localparam logic [FW-1:0] FILL_MAX = FW'(W - 1);
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("mealy_seq_detector: W must be in 2..16");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("mealy_seq_detector: CNT_W out of range");
    end
    logic [W-1:0]  pat_q;
    logic [W-2:0]  hist;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_d;
    logic [W-1:0]  win;
    // win is the candidate W-bit window with the live bit appended as newest
    always_comb begin
        win    = {hist, x_in};
        y_out  = x_valid & ~cfg_load & (fill == FILL_MAX) & (win == pat_q);
        fill_d = (y_out & ~overlap) ? '0 : (fill == FILL_MAX) ? fill : fill + 1'b1;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            pat_q <= DEF_PATTERN;
            hist  <= '0;
            fill  <= '0;
        end else if (cfg_load) begin
            pat_q <= pattern_in;
            hist  <= '0;
            fill  <= '0;
        end else if (x_valid) begin
            hist <= win[W-2:0];
            fill <= fill_d;
        end
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock(clock),
        .reset(reset),
        .clr  (cfg_load),
        .inc  (y_out),
        .count(match_count),
        .sat  (match_sat)
    );
endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb_mealy_seq_detector: directed checks of a W=2/CNT_W=3 and a W=4 detector instance
module tb_mealy_seq_detector;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    logic a_rst, a_x, a_v, a_ov, a_cfg, a_y, a_sat;
    logic [1:0] a_pat;
    logic [2:0] a_cnt;
    logic d_rst, d_x, d_v, d_ov, d_cfg, d_y, d_sat;
    logic [3:0] d_pat;
    logic [7:0] d_cnt;
    mealy_seq_detector #(.W(2), .CNT_W(3), .DEF_PATTERN(2'b00)) dut_a (
        .clock(clk), .reset(a_rst), .x_in(a_x), .x_valid(a_v), .overlap(a_ov),
        .cfg_load(a_cfg), .pattern_in(a_pat), .y_out(a_y), .match_count(a_cnt), .match_sat(a_sat)
    );
    mealy_seq_detector #(.W(4), .CNT_W(8), .DEF_PATTERN(4'b0000)) dut_d (
        .clock(clk), .reset(d_rst), .x_in(d_x), .x_valid(d_v), .overlap(d_ov),
        .cfg_load(d_cfg), .pattern_in(d_pat), .y_out(d_y), .match_count(d_cnt), .match_sat(d_sat)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic sa(input logic x, input logic v, input logic cfg, input logic [1:0] pat, input logic ey);
        a_x = x; a_v = v; a_cfg = cfg; a_pat = pat;
        #1 chk("a_y_out", 32'(a_y), 32'(ey));
        @(negedge clk);
    endtask
    task automatic sd(input logic x, input logic v, input logic cfg, input logic [3:0] pat, input logic ey);
        d_x = x; d_v = v; d_cfg = cfg; d_pat = pat;
        #1 chk("d_y_out", 32'(d_y), 32'(ey));
        @(negedge clk);
    endtask
    initial begin
        logic [6:0] s7;
        logic [6:0] e7;
        a_rst = 0; a_x = 0; a_v = 0; a_ov = 0; a_cfg = 0; a_pat = 0;
        d_rst = 0; d_x = 0; d_v = 0; d_ov = 0; d_cfg = 0; d_pat = 0;
        #2;
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_sat", 32'(a_sat), 0);
        chk("rst_d_cnt", 32'(d_cnt), 0);
        chk("rst_d_sat", 32'(d_sat), 0);
        a_v = 1;
        #1 chk("rst_a_y_valid", 32'(a_y), 0);
        a_v = 0;
        @(negedge clk);
        a_rst = 1; d_rst = 1;
        // default pattern 00 with overlap: stream 1,0,0,0,1
        a_ov = 1;
        sa(1, 1, 0, 2'b00, 0);
        sa(0, 1, 0, 2'b00, 0);
        sa(0, 1, 0, 2'b00, 1);
        sa(0, 1, 0, 2'b00, 1);
        sa(1, 1, 0, 2'b00, 0);
        chk("a_cnt_def", 32'(a_cnt), 2);
        chk("a_sat_def", 32'(a_sat), 0);
        sa(1, 1, 1, 2'b11, 0);
        chk("a_cnt_cfg", 32'(a_cnt), 0);
        for (int i = 1; i <= 10; i++) begin
            sa(1, 1, 0, 2'b11, i > 1);
            chk("a_cnt_sat", 32'(a_cnt), (i - 1 > 7) ? 7 : i - 1);
            chk("a_sat_flag", 32'(a_sat), 32'(i - 1 >= 7));
        end
        sa(0, 1, 0, 2'b00, 0);
        sa(0, 1, 0, 2'b00, 0);
        chk("a_cnt_hold", 32'(a_cnt), 7);
        sa(0, 1, 1, 2'b11, 0);
        chk("a_sat_clr", 32'(a_sat), 0);
        chk("a_cnt_clr", 32'(a_cnt), 0);
        // W=4 pattern 1011 without and with overlap
        s7 = 7'b1011011;
        d_ov = 0;
        sd(0, 1, 1, 4'b1011, 0);
        e7 = 7'b0001000;
        for (int k = 0; k < 7; k++) sd(s7[6-k], 1, 0, 4'b1011, e7[6-k]);
        chk("d_cnt_novl", 32'(d_cnt), 1);
        sd(0, 1, 1, 4'b1011, 0);
        d_ov = 1;
        e7 = 7'b0001001;
        for (int k = 0; k < 7; k++) sd(s7[6-k], 1, 0, 4'b1011, e7[6-k]);
        chk("d_cnt_ovl", 32'(d_cnt), 2);
        // gap of invalid cycles holds history
        d_ov = 0;
        sd(0, 1, 1, 4'b1011, 0);
        sd(1, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(1, 1, 0, 4'b1011, 0);
        for (int k = 0; k < 3; k++) sd(1, 0, 0, 4'b1011, 0);
        chk("d_cnt_gap", 32'(d_cnt), 0);
        sd(1, 1, 0, 4'b1011, 1);
        chk("d_cnt_gap_end", 32'(d_cnt), 1);
        // asynchronous reset between edges
        sd(1, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(1, 1, 0, 4'b1011, 0);
        d_x = 1; d_v = 1;
        #1 chk("d_y_pre_rst", 32'(d_y), 1);
        #1 d_rst = 0;
        #1 chk("d_y_async_rst", 32'(d_y), 0);
        chk("d_cnt_async_rst", 32'(d_cnt), 0);
        chk("d_sat_async_rst", 32'(d_sat), 0);
        @(negedge clk);
        d_rst = 1;
        sd(1, 1, 0, 4'b1011, 0);
        chk("d_cnt_post_rst", 32'(d_cnt), 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 1);
        chk("d_cnt_def_pat", 32'(d_cnt), 1);
        // cfg_load on a completing bit discards the match
        sd(0, 1, 1, 4'b1011, 0);
        sd(1, 1, 0, 4'b1011, 0);
        sd(0, 1, 0, 4'b1011, 0);
        sd(1, 1, 0, 4'b1011, 0);
        sd(1, 1, 1, 4'b0110, 0);
        chk("d_cnt_cfg_cmp", 32'(d_cnt), 0);
        sd(0, 1, 0, 4'b0000, 0);
        sd(1, 1, 0, 4'b0000, 0);
        sd(1, 1, 0, 4'b0000, 0);
        sd(0, 1, 0, 4'b0000, 1);
        chk("d_cnt_new_pat", 32'(d_cnt), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
